// File: rtl/inst_fetch_queue.sv
// Dual-lane instruction buffer between IF and ID: up to two pushes and two
// issues per cycle over a circular store, with explicit occupancy tracking.
module inst_fetch_queue #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 8,
  parameter int DUAL_ISSUE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      in_line1_valid_i,
  input  logic                      in_line2_valid_i,
  input  logic [2*DATA_W-1:0]       in_data_i,
  output logic                      allowin_o,
  input  logic [1:0]                issue_cnt_i,
  output logic                      out_line1_valid_o,
  output logic                      out_line2_valid_o,
  output logic [2*DATA_W-1:0]       out_data_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = AW + 2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr_p1;
  logic [AW-1:0]     rd_ptr_p1;
  logic [CW-1:0]     count;
  logic [1:0]        issue_clamped;
  logic [1:0]        pop_n;
  logic [1:0]        push_n;
  logic [XW-1:0]     credit;

  assign wr_ptr_p1 = wr_ptr + AW'(1);
  assign rd_ptr_p1 = rd_ptr + AW'(1);

  // Issue requests are clamped to the lane count and to what is actually
  // held, so over-issue can never move rd_ptr past valid data.
  always_comb begin
    issue_clamped = (issue_cnt_i == 2'd3) ? 2'd2 : issue_cnt_i;
    if ((DUAL_ISSUE == 0) && (issue_clamped > 2'd1)) begin
      issue_clamped = 2'd1;
    end
    pop_n = (CW'(issue_clamped) > count) ? count[1:0] : issue_clamped;
  end

  // Free space plus same-cycle pop credit decides whether a full pair fits.
  always_comb begin
    credit    = XW'(DEPTH) - XW'(count) + XW'(pop_n);
    allowin_o = (credit >= XW'(2));
    push_n    = 2'd0;
    if (allowin_o && in_line1_valid_i) begin
      push_n = in_line2_valid_i ? 2'd2 : 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_n != 2'd0) begin
        mem[wr_ptr] <= in_data_i[DATA_W-1:0];
      end
      if (push_n == 2'd2) begin
        mem[wr_ptr_p1] <= in_data_i[2*DATA_W-1:DATA_W];
      end
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // Validity comes from count alone; storage is never bypassed.
  assign out_data_o        = {mem[rd_ptr_p1], mem[rd_ptr]};
  assign out_line1_valid_o = (count >= CW'(1));
  assign out_line2_valid_o = (DUAL_ISSUE != 0) && (count >= CW'(2));
  assign count_o           = count;
  assign empty_o           = (count == '0);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a dual-issue instance checked against
// a FIFO model plus a single-issue instance checked with fixed expectations.
module tb_inst_fetch_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0;
  logic          in_line1_valid_i = 1'b0;
  logic          in_line2_valid_i = 1'b0;
  logic [2*DW-1:0] in_data_i = '0;
  logic          allowin_o;
  logic [1:0]    issue_cnt_i = 2'd0;
  logic          out_line1_valid_o;
  logic          out_line2_valid_o;
  logic [2*DW-1:0] out_data_o;
  logic [3:0]    count_o;
  logic          empty_o;

  logic          si_flush = 1'b0;
  logic          si_l1 = 1'b0;
  logic          si_l2 = 1'b0;
  logic [2*DW-1:0] si_data = '0;
  logic          si_allowin;
  logic [1:0]    si_issue = 2'd0;
  logic          si_o1v;
  logic          si_o2v;
  logic [2*DW-1:0] si_out;
  logic [3:0]    si_count;
  logic          si_empty;

  int passed = 0;
  int total  = 0;
  logic [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  inst_fetch_queue #(.DATA_W(DW), .DEPTH(DEPTH), .DUAL_ISSUE(1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_line1_valid_i(in_line1_valid_i), .in_line2_valid_i(in_line2_valid_i),
    .in_data_i(in_data_i), .allowin_o(allowin_o), .issue_cnt_i(issue_cnt_i),
    .out_line1_valid_o(out_line1_valid_o), .out_line2_valid_o(out_line2_valid_o),
    .out_data_o(out_data_o), .count_o(count_o), .empty_o(empty_o)
  );

  inst_fetch_queue #(.DATA_W(DW), .DEPTH(DEPTH), .DUAL_ISSUE(0)) dut_si (
    .clk(clk), .rst(rst), .flush_i(si_flush),
    .in_line1_valid_i(si_l1), .in_line2_valid_i(si_l2),
    .in_data_i(si_data), .allowin_o(si_allowin), .issue_cnt_i(si_issue),
    .out_line1_valid_o(si_o1v), .out_line2_valid_o(si_o2v),
    .out_data_o(si_out), .count_o(si_count), .empty_o(si_empty)
  );

  task automatic set_in(input logic l1, input logic l2, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [1:0] iss, input logic fl);
    @(negedge clk);
    in_line1_valid_i = l1;
    in_line2_valid_i = l2;
    in_data_i        = {d2, d1};
    issue_cnt_i      = iss;
    flush_i          = fl;
    #1;
  endtask

  // Advance one edge and apply the same transaction to the reference FIFO.
  task automatic tick();
    int sz;
    int iss;
    int pop;
    int push;
    bit allow;
    @(posedge clk);
    sz    = sb_q.size();
    iss   = (issue_cnt_i == 2'd3) ? 2 : int'(issue_cnt_i);
    pop   = (iss < sz) ? iss : sz;
    allow = (DEPTH - sz + pop) >= 2;
    push  = (allow && in_line1_valid_i) ? (in_line2_valid_i ? 2 : 1) : 0;
    if (flush_i) begin
      sb_q.delete();
    end else begin
      repeat (pop) void'(sb_q.pop_front());
      if (push >= 1) sb_q.push_back(in_data_i[DW-1:0]);
      if (push == 2) sb_q.push_back(in_data_i[2*DW-1:DW]);
    end
    #1;
    in_line1_valid_i = 1'b0;
    in_line2_valid_i = 1'b0;
    in_data_i        = '0;
    issue_cnt_i      = 2'd0;
    flush_i          = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++; if (count_o !== 4'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count_o); else passed++;
    total++; if (empty_o !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", empty_o); else passed++;
    total++; if (allowin_o !== 1'b1) $display("[TB] FAIL reset_allowin: got %b expected 1", allowin_o); else passed++;
    total++; if (out_data_o !== 64'd0) $display("[TB] FAIL reset_data: got %h expected 0", out_data_o); else passed++;
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b1, 1'b1, 32'h1111_0001, 32'h1111_0002, 2'd0, 1'b0);
    tick();
    total++; if (count_o !== 4'd2) $display("[TB] FAIL pre_reset_count: got %0d expected 2", count_o); else passed++;
    // Reset lands between edges and must act immediately.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb_q.delete();
    total++; if (count_o !== 4'd0) $display("[TB] FAIL async_reset_count: got %0d expected 0", count_o); else passed++;
    total++; if ({out_line1_valid_o, out_line2_valid_o} !== 2'b00) $display("[TB] FAIL async_reset_valids: got %b expected 00", {out_line1_valid_o, out_line2_valid_o}); else passed++;
    total++; if (empty_o !== 1'b1) $display("[TB] FAIL async_reset_empty: got %b expected 1", empty_o); else passed++;
    total++; if (allowin_o !== 1'b1) $display("[TB] FAIL async_reset_allowin: got %b expected 1", allowin_o); else passed++;
    total++; if (out_data_o !== 64'd0) $display("[TB] FAIL async_reset_data: got %h expected 0", out_data_o); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, 32'hA000_0000 + 32'(2*i), 32'hA000_0000 + 32'(2*i+1), 2'd0, 1'b0);
      total++; if (allowin_o !== 1'b1) $display("[TB] FAIL fill_allowin_%0d: got %b expected 1", i, allowin_o); else passed++;
      tick();
    end
    total++; if (count_o !== 4'd8) $display("[TB] FAIL full_count: got %0d expected 8", count_o); else passed++;
    total++; if (allowin_o !== 1'b0) $display("[TB] FAIL full_allowin: got %b expected 0", allowin_o); else passed++;
    total++; if (out_line2_valid_o !== 1'b1) $display("[TB] FAIL full_valid2: got %b expected 1", out_line2_valid_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 1'b0);
      total++;
      if (out_data_o !== {32'hA000_0000 + 32'(2*i+1), 32'hA000_0000 + 32'(2*i)})
        $display("[TB] FAIL drain_pair_%0d: got %h expected %h", i, out_data_o, {32'hA000_0000 + 32'(2*i+1), 32'hA000_0000 + 32'(2*i)});
      else passed++;
      tick();
    end
    total++; if (count_o !== 4'd0) $display("[TB] FAIL drain_count: got %0d expected 0", count_o); else passed++;
    total++; if (empty_o !== 1'b1) $display("[TB] FAIL drain_empty: got %b expected 1", empty_o); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] exp_lo;
    logic [DW-1:0] exp_hi;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 32'hC000_0000 + 32'(2*i), 32'hC000_0000 + 32'(2*i+1), 2'd0, 1'b0);
      tick();
    end
    set_in(1'b1, 1'b0, 32'hC000_0006, 32'd0, 2'd0, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 32'hB000_0000, 32'hB000_0001, 2'd1, 1'b0);
    total++; if (count_o !== 4'd7) $display("[TB] FAIL sim_pre_count: got %0d expected 7", count_o); else passed++;
    total++; if (allowin_o !== 1'b1) $display("[TB] FAIL sim_allowin: got %b expected 1", allowin_o); else passed++;
    total++; if (out_data_o[DW-1:0] !== 32'hC000_0000) $display("[TB] FAIL sim_oldest: got %h expected c0000000", out_data_o[DW-1:0]); else passed++;
    tick();
    total++; if (count_o !== 4'd8) $display("[TB] FAIL sim_count: got %0d expected 8", count_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 1'b0);
      exp_lo = sb_q[0];
      exp_hi = sb_q[1];
      total++; if (out_data_o !== {exp_hi, exp_lo}) $display("[TB] FAIL sim_drain_%0d: got %h expected %h", i, out_data_o, {exp_hi, exp_lo}); else passed++;
      if (i == 3) begin
        total++; if (out_data_o !== {32'hB000_0001, 32'hB000_0000}) $display("[TB] FAIL wrap_pair: got %h expected b0000001b0000000", out_data_o); else passed++;
      end
      tick();
    end
    total++; if (count_o !== 4'd0) $display("[TB] FAIL sim_end_count: got %0d expected 0", count_o); else passed++;
  endtask

  task automatic test_flush();
    set_in(1'b1, 1'b1, 32'hD000_0000, 32'hD000_0001, 2'd0, 1'b0); tick();
    set_in(1'b1, 1'b1, 32'hD000_0002, 32'hD000_0003, 2'd0, 1'b0); tick();
    set_in(1'b1, 1'b0, 32'hD000_0004, 32'd0, 2'd0, 1'b0); tick();
    total++; if (count_o !== 4'd5) $display("[TB] FAIL flush_pre_count: got %0d expected 5", count_o); else passed++;
    set_in(1'b1, 1'b1, 32'hF000_0000, 32'hF000_0001, 2'd2, 1'b1);
    tick();
    total++; if (count_o !== 4'd0) $display("[TB] FAIL flush_count: got %0d expected 0", count_o); else passed++;
    total++; if ({out_line1_valid_o, out_line2_valid_o} !== 2'b00) $display("[TB] FAIL flush_valids: got %b expected 00", {out_line1_valid_o, out_line2_valid_o}); else passed++;
    set_in(1'b1, 1'b0, 32'h6000_0000, 32'd0, 2'd0, 1'b0);
    total++; if (out_line1_valid_o !== 1'b0) $display("[TB] FAIL no_bypass: got %b expected 0", out_line1_valid_o); else passed++;
    tick();
    total++; if (count_o !== 4'd1) $display("[TB] FAIL post_flush_count: got %0d expected 1", count_o); else passed++;
    total++; if (out_data_o[DW-1:0] !== 32'h6000_0000) $display("[TB] FAIL post_flush_head: got %h expected 60000000", out_data_o[DW-1:0]); else passed++;
  endtask

  task automatic test_edge_inputs();
    set_in(1'b0, 1'b1, 32'hE000_0000, 32'hE000_0001, 2'd0, 1'b0);
    tick();
    total++; if (count_o !== 4'd1) $display("[TB] FAIL lane2_only_count: got %0d expected 1", count_o); else passed++;
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 2'd3, 1'b0);
    tick();
    total++; if (count_o !== 4'd0) $display("[TB] FAIL issue3_count: got %0d expected 0", count_o); else passed++;
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 1'b0);
    total++; if (allowin_o !== 1'b1) $display("[TB] FAIL overissue_allowin: got %b expected 1", allowin_o); else passed++;
    tick();
    total++; if (count_o !== 4'd0) $display("[TB] FAIL overissue_count: got %0d expected 0", count_o); else passed++;
    set_in(1'b1, 1'b1, 32'h7000_0000, 32'h7000_0001, 2'd0, 1'b0);
    tick();
    total++; if (out_data_o !== {32'h7000_0001, 32'h7000_0000}) $display("[TB] FAIL overissue_order: got %h expected 7000000170000000", out_data_o); else passed++;
    total++; if (count_o !== 4'(sb_q.size())) $display("[TB] FAIL overissue_sb_count: got %0d expected %0d", count_o, sb_q.size()); else passed++;
    set_in(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
    tick();
  endtask

  task automatic test_single_issue();
    @(negedge clk);
    si_l1 = 1'b1; si_l2 = 1'b1; si_data = {32'h5000_0001, 32'h5000_0000}; si_issue = 2'd0;
    @(posedge clk); #1;
    si_l1 = 1'b0; si_l2 = 1'b0; si_data = '0;
    #1;
    total++; if (si_count !== 4'd2) $display("[TB] FAIL si_count_fill: got %0d expected 2", si_count); else passed++;
    total++; if (si_o2v !== 1'b0) $display("[TB] FAIL si_valid2_fill: got %b expected 0", si_o2v); else passed++;
    total++; if (si_out[DW-1:0] !== 32'h5000_0000) $display("[TB] FAIL si_head0: got %h expected 50000000", si_out[DW-1:0]); else passed++;
    @(negedge clk);
    si_issue = 2'd2;
    #1;
    total++; if (si_o2v !== 1'b0) $display("[TB] FAIL si_valid2_issue: got %b expected 0", si_o2v); else passed++;
    @(posedge clk); #1;
    total++; if (si_count !== 4'd1) $display("[TB] FAIL si_count_pop1: got %0d expected 1", si_count); else passed++;
    total++; if (si_out[DW-1:0] !== 32'h5000_0001) $display("[TB] FAIL si_head1: got %h expected 50000001", si_out[DW-1:0]); else passed++;
    @(posedge clk); #1;
    total++; if (si_count !== 4'd0) $display("[TB] FAIL si_count_pop2: got %0d expected 0", si_count); else passed++;
    total++; if (si_empty !== 1'b1) $display("[TB] FAIL si_empty: got %b expected 1", si_empty); else passed++;
    si_issue = 2'd0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_flush();
    test_edge_inputs();
    test_single_issue();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
